spi_reg_bank: RTL

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI-programmed register bank: 32-bit mode-0 frames (preamble/address/pad/data) write, read or commit registers.
// Optional SPI_REG_BANK_SHADOW_EN stages writes in a shadow array that a commit frame copies to the active array.
module spi_reg_bank #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sck,
  input  logic                    cs,
  input  logic                    mosi,
  output logic                    miso,
  output logic [DEPTH*DATA_W-1:0] coeff,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    err,
  output logic [2:0]              dbg_state
);
  // wr_valid is a one-cycle strobe with no ready/back-pressure; wr_addr and
  // wr_data are meaningful only in the cycle wr_valid is high.

  localparam int FRAME_W = 8 + ADDR_W + 4 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0] PRE_WR = 8'hFB;
  localparam logic [7:0] PRE_RD = 8'hFA;
  localparam logic [7:0] PRE_CM = 8'hFC;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ADDR, S_PAD, S_DATA, S_DONE
  } state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_CM} op_t;

  state_t                  state_q, state_d;
  op_t                     op_q, op_d;
  logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sck_prev_q, cs_prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [6:0]              pre_q, pre_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [DATA_W-1:0]       rd_sr_q, rd_sr_d;
  logic                    bad_q, bad_d;
  logic                    miso_q, miso_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [DATA_W-1:0]       act_q [DEPTH];
  logic [DATA_W-1:0]       act_d [DEPTH];
`ifdef SPI_REG_BANK_SHADOW_EN
  logic [DATA_W-1:0]       sh_q [DEPTH];
  logic [DATA_W-1:0]       sh_d [DEPTH];
`endif

  logic              sck_s, cs_s, mosi_s;
  logic              cs_fall, cs_rise, sck_rise, sck_fall;
  logic [7:0]        pre_full;
  logic [ADDR_W-1:0] addr_full;
  logic [DATA_W-1:0] data_full;
  logic              addr_ok, in_frame, field_last;
  logic [IDX_W-1:0]  addr_idx, wr_idx;
  logic [DATA_W-1:0] rd_word;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign sck_rise  = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall  = ~sck_s & sck_prev_q & ~cs_s;
  assign pre_full  = {pre_q, mosi_s};
  assign addr_full = ADDR_W'({addr_q, mosi_s});
  assign data_full = DATA_W'({data_q, mosi_s});
  assign addr_ok   = ({1'b0, addr_full} < DEPTH_V);
  assign addr_idx  = IDX_W'(addr_full);
  assign wr_idx    = IDX_W'(addr_q);
  assign in_frame  = (state_q == S_PREAMBLE) || (state_q == S_ADDR) ||
                     (state_q == S_PAD) || (state_q == S_DATA);
`ifdef SPI_REG_BANK_SHADOW_EN
  assign rd_word   = sh_q[addr_idx];
`else
  assign rd_word   = act_q[addr_idx];
`endif

  always_comb begin
    field_last = 1'b0;
    case (state_q)
      S_PREAMBLE: field_last = (cnt_q == CNT_W'(7));
      S_ADDR:     field_last = (cnt_q == CNT_W'(ADDR_W - 1));
      S_PAD:      field_last = (cnt_q == CNT_W'(3));
      S_DATA:     field_last = (cnt_q == CNT_W'(DATA_W - 1));
      default:    field_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a CS fall restarts a frame from any state
  always_comb begin
    state_d = state_q;
    if (cs_fall) begin
      state_d = S_PREAMBLE;
    end else if (cs_rise) begin
      state_d = S_IDLE;
    end else if (sck_rise && field_last) begin
      case (state_q)
        S_PREAMBLE: state_d = (pre_full == PRE_WR || pre_full == PRE_RD ||
                               pre_full == PRE_CM) ? S_ADDR : S_DONE;
        S_ADDR:     state_d = S_PAD;
        S_PAD:      state_d = S_DATA;
        S_DATA:     state_d = S_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    dbg_state = state_q;
    miso      = miso_q;
    wr_valid  = wr_valid_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    busy      = busy_q;
    err       = err_q;
    coeff     = '0;
    for (int k = 0; k < DEPTH; k++) coeff[k*DATA_W +: DATA_W] = act_q[k];
  end

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_sr_d     = rd_sr_q;
    op_d        = op_q;
    bad_d       = bad_q;
    miso_d      = miso_q;
    err_d       = err_q;
    busy_d      = busy_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    act_d       = act_q;
`ifdef SPI_REG_BANK_SHADOW_EN
    sh_d        = sh_q;
`endif
    if (sck_rise && in_frame) begin
      cnt_d = field_last ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        S_PREAMBLE: begin
          pre_d = pre_full[6:0];
          if (field_last) begin
            case (pre_full)
              PRE_WR:  op_d = OP_WR;
              PRE_RD:  op_d = OP_RD;
              PRE_CM:  op_d = OP_CM;
              default: err_d = 1'b1;
            endcase
          end
        end
        S_ADDR: begin
          addr_d = addr_full;
          if (field_last) begin
            // Commit frames carry no meaningful address
            bad_d   = (op_q != OP_CM) && !addr_ok;
            err_d   = err_q | bad_d;
            rd_sr_d = (op_q == OP_RD && addr_ok) ? rd_word : '0;
          end
        end
        S_DATA: begin
          data_d = data_full;
          if (field_last) begin
            if (!bad_q) err_d = 1'b0;
            if (op_q == OP_WR && !bad_q) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = data_full;
`ifdef SPI_REG_BANK_SHADOW_EN
              sh_d[wr_idx] = data_full;
`else
              act_d[wr_idx] = data_full;
`endif
            end
`ifdef SPI_REG_BANK_SHADOW_EN
            if (op_q == OP_CM) act_d = sh_q;
`endif
          end
        end
        default: ;
      endcase
    end
    if (sck_fall) begin
      miso_d = (state_q == S_DATA) ? rd_sr_q[DATA_W-1] : 1'b0;
      if (state_q == S_DATA) rd_sr_d = rd_sr_q << 1;
    end
    if (cs_rise) begin
      miso_d = 1'b0;
      busy_d = 1'b0;
      if (in_frame) err_d = 1'b1;
    end
    if (cs_fall) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      bad_d  = 1'b0;
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      cnt_q       <= '0;
      pre_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_sr_q     <= '0;
      op_q        <= OP_WR;
      bad_q       <= 1'b0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        act_q[k] <= '0;
`ifdef SPI_REG_BANK_SHADOW_EN
        sh_q[k]  <= '0;
`endif
      end
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_sr_q     <= rd_sr_d;
      op_q        <= op_d;
      bad_q       <= bad_d;
      miso_q      <= miso_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      act_q       <= act_d;
`ifdef SPI_REG_BANK_SHADOW_EN
      sh_q        <= sh_d;
`endif
    end
  end

endmodule
